mandel_prefetch_scheduler: RTL

//  Raster-order request scheduler between the VGA consumer and mandelbrot_engine. Walks pixel coords

---
 rtl/fractal_pkg.sv | 16 +
 rtl/sched_result_fifo.sv | 59 +++++
 rtl/mandel_prefetch_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fractal_pkg.sv
// Shared fractal-viewer definitions: screen geometry, pixel coordinate width
// and the prefetch scheduler state encoding.
package fractal_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int COORD_PIX_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } sched_state_e;

endpackage

// File: rtl/sched_result_fifo.sv
// In-order result FIFO for the prefetch scheduler. Synchronous push/pop,
// synchronous clear, head visible combinationally from storage (zero when
// empty). DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sched_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             full;

  assign valid   = (level != '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_push = push && !clear;
  assign do_pop  = pop && valid && !clear;
  assign head    = valid ? mem[rd_ptr] : '0;

  // Storage write; no reset needed since level gates what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // The upstream credit scheme must never push into a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(do_push && full));

endmodule

// File: rtl/mandel_prefetch_scheduler.sv
// Raster-order request scheduler sitting between the VGA consumer and the
// mandelbrot engine. Walks pixel coordinates ahead of the beam, issues them
// to the engine, collects iteration counts in order and serves one per pop.
// Optional build macro SCHED_STATS_EN adds a saturating underflow_count port.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready.
// Once req_valid is raised, req_valid/req_x/req_y stay stable until that
// transfer or a frame_start; dropping enable never retracts it. rsp_valid is
// a one-cycle strobe carrying the result for the oldest outstanding request.
module mandel_prefetch_scheduler
  import fractal_pkg::*;
#(
  parameter int H_ACTIVE   = SCREEN_W,
  parameter int V_ACTIVE   = SCREEN_H,
  parameter int ITER_WIDTH = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_OUTSTD = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          frame_start,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [COORD_PIX_W-1:0]        req_x,
  output logic [COORD_PIX_W-1:0]        req_y,
  input  logic                          rsp_valid,
  input  logic [ITER_WIDTH-1:0]         rsp_iter,
  input  logic                          pix_pop,
  output logic                          pix_valid,
  output logic [ITER_WIDTH-1:0]         pix_iter,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef SCHED_STATS_EN
  output logic [15:0]                   underflow_count,
`endif
  output sched_state_e                  state_dbg
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = COORD_PIX_W;
  localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

  sched_state_e  state;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic [LW-1:0] outstanding;
  logic [LW-1:0] out_next;
  logic [LW-1:0] level_next;
  logic          xfer;
  logic          rsp_take;
  logic          fifo_push;
  logic          pop_eff;
  logic          last_pix;
  logic          credit_ok;

  // The walker registers are the request coordinates themselves, so they
  // only move on a transfer and are trivially stable while a request waits.
  assign req_x     = x_q;
  assign req_y     = y_q;
  assign state_dbg = state;

  assign xfer      = req_valid && req_ready;
  assign rsp_take  = rsp_valid && (outstanding != '0);
  assign fifo_push = rsp_take && !frame_start && ((state == RUN) || (state == DONE));
  assign pop_eff   = pix_pop && pix_valid;
  assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);

  // Next-cycle credit picture: in-flight count and FIFO occupancy after
  // this edge's transfer, response, push and pop have all been applied.
  always_comb begin
    out_next = outstanding;
    if (xfer && !rsp_take)      out_next = outstanding + LW'(1);
    else if (!xfer && rsp_take) out_next = outstanding - LW'(1);
    level_next = fifo_level;
    if (fifo_push && !pop_eff)      level_next = fifo_level + LW'(1);
    else if (!fifo_push && pop_eff) level_next = fifo_level - LW'(1);
    credit_ok = enable
             && ((int'(level_next) + int'(out_next)) < FIFO_DEPTH)
             && (int'(out_next) < MAX_OUTSTD);
  end

  // Control FSM, raster walker and in-flight request counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      req_valid   <= 1'b0;
      outstanding <= '0;
      underflow   <= 1'b0;
    end else begin
      underflow   <= pix_pop && !pix_valid;
      outstanding <= out_next;
      if (frame_start) begin
        x_q       <= '0;
        y_q       <= '0;
        req_valid <= 1'b0;
        state     <= (state == IDLE) ? RUN : FLUSH;
      end else begin
        if (xfer) begin
          if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= (y_q == Y_LAST) ? '0 : y_q + CW'(1);
          end else begin
            x_q <= x_q + CW'(1);
          end
        end
        case (state)
          RUN: begin
            if (xfer && last_pix) begin
              state     <= DONE;
              req_valid <= 1'b0;
            end else if (req_valid && !req_ready) begin
              req_valid <= 1'b1;
            end else begin
              req_valid <= credit_ok;
            end
          end
          FLUSH: begin
            req_valid <= 1'b0;
            if (out_next == '0) state <= RUN;
          end
          default: req_valid <= 1'b0;
        endcase
      end
    end
  end

`ifdef SCHED_STATS_EN
  // Saturating count of underflow pulses; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_count <= '0;
    end else if (pix_pop && !pix_valid && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end
`endif

  sched_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ITER_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (frame_start),
    .push      (fifo_push),
    .push_data (rsp_iter),
    .pop       (pix_pop),
    .head      (pix_iter),
    .valid     (pix_valid),
    .level     (fifo_level)
  );

endmodule
